// File: rtl/sum_sched_pkg.sv
// Shared definitions for the round-robin summation scheduler.
package sum_sched_pkg;

   localparam int DEFAULT_WIDTH = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sum_acc_dp.sv
// Summation datapath: running index i, accumulator c and sticky carry flag.
module sum_acc_dp
   import sum_sched_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] n_in,
   output logic [WIDTH-1:0] c,
   output logic             ovf_acc,
   output logic             term
);

   logic [WIDTH-1:0] i;
   logic [WIDTH-1:0] n_lat;
   logic [WIDTH:0]   sum_ext;

   assign sum_ext = {1'b0, c} + {1'b0, i};
   assign term    = (i >= n_lat);

   // The bound is captured at load so later changes on n_in cannot disturb a running job
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i       <= '0;
         c       <= '0;
         n_lat   <= '0;
         ovf_acc <= 1'b0;
      end else if (load) begin
         i       <= '0;
         c       <= '0;
         n_lat   <= n_in;
         ovf_acc <= 1'b0;
      end else if (step) begin
         i       <= i + 1'b1;
         c       <= sum_ext[WIDTH-1:0];
         ovf_acc <= ovf_acc | sum_ext[WIDTH];
      end
   end

endmodule

// File: rtl/sum_sched.sv
// Two-requester round-robin scheduler that runs one summation job at a time.
module sum_sched
   import sum_sched_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] n0,
   input  logic             req1,
   input  logic [WIDTH-1:0] n1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] result,
   output logic             ovf
);

   state_t           state;
   logic             last_served;
   logic             owner;
   logic             winner;
   logic             any_req;
   logic             load;
   logic             step;
   logic [WIDTH-1:0] n_sel;
   logic [WIDTH-1:0] c;
   logic             ovf_acc;
   logic             term;

   // On a tie the requester not served last wins; a lone request always wins
   assign winner  = (req0 && req1) ? ~last_served : ~req0;
   assign any_req = req0 | req1;
   assign n_sel   = winner ? n1 : n0;
   assign load    = (state == IDLE) && any_req;
   assign step    = (state == RUN) && !term;

   sum_acc_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .step    (step),
      .n_in    (n_sel),
      .c       (c),
      .ovf_acc (ovf_acc),
      .term    (term)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_served <= 1'b1;
         owner       <= 1'b0;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         done_id     <= 1'b0;
         result      <= '0;
         ovf         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner <= winner;
                  gnt0  <= ~winner;
                  gnt1  <= winner;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (term) begin
                  result      <= c;
                  ovf         <= ovf_acc;
                  done_id     <= owner;
                  last_served <= owner;
                  done        <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               gnt0  <= 1'b0;
               gnt1  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sum_sched.sv
// Scoreboard bench for sum_sched: closed-form job model feeds a queue, monitor checks outputs.
module tb_sum_sched;

   localparam int W = 11;

   typedef struct {
      int id;
      int res;
      int ovf;
      int edgeNo;
   } job_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0 = 1'b0;
   logic         req1 = 1'b0;
   logic [W-1:0] n0 = '0;
   logic [W-1:0] n1 = '0;
   logic         gnt0;
   logic         gnt1;
   logic         busy;
   logic         done;
   logic         done_id;
   logic [W-1:0] result;
   logic         ovf;

   job_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   edgeCnt = 0;
   int   freeEdge = 1 << 30;
   int   gStart = 0;
   int   gEnd = -1;
   int   gOwner = 0;
   int   lastServedM = 1;
   int   heldRes = 0;
   int   heldOvf = 0;
   int   heldId = 0;

   sum_sched #(
      .WIDTH (W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req0    (req0),
      .n0      (n0),
      .req1    (req1),
      .n1      (n1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .result  (result),
      .ovf     (ovf)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edgeCnt);
      end
   endtask

   // A job's result is the closed-form triangular number; overflow means it reached 2^W
   task automatic modelStep();
      int     k;
      int     n;
      int     win;
      longint s;
      job_t   j;
      k = edgeCnt + 1;
      if (!rst && k >= freeEdge && (req0 || req1)) begin
         if (req0 && req1) win = (lastServedM == 1) ? 0 : 1;
         else win = req0 ? 0 : 1;
         n = win ? int'(n1) : int'(n0);
         s = longint'(n) * longint'(n - 1) / 2;
         j.id = win;
         j.res = int'(s % (longint'(1) << W));
         j.ovf = (s >= (longint'(1) << W)) ? 1 : 0;
         j.edgeNo = k + n + 1;
         sb.push_back(j);
         gStart = k;
         gEnd = k + n + 1;
         gOwner = win;
         lastServedM = win;
         freeEdge = k + n + 3;
      end
   endtask

   task automatic modelReset();
      sb.delete();
      gEnd = -1;
      gStart = 0;
      lastServedM = 1;
      heldRes = 0;
      heldOvf = 0;
      heldId = 0;
      freeEdge = 1 << 30;
   endtask

   task automatic applyStimulus(input logic r0, input logic r1, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      req0 = r0;
      req1 = r1;
      n0 = a;
      n1 = b;
      modelStep();
   endtask

   task automatic idle(input int cycles);
      for (int t = 0; t < cycles; t++) applyStimulus(1'b0, 1'b0, n0, n1);
   endtask

   // Reset in the middle of whatever is running, checking that outputs clear without a clock edge
   task automatic pulseReset(input logic r0, input logic r1, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      rst = 1'b1;
      req0 = r0;
      req1 = r1;
      n0 = a;
      n1 = b;
      modelReset();
      #1;
      checkOutput("rst_gnt0", int'(gnt0), 0);
      checkOutput("rst_gnt1", int'(gnt1), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_done_id", int'(done_id), 0);
      checkOutput("rst_result", int'(result), 0);
      checkOutput("rst_ovf", int'(ovf), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      freeEdge = edgeCnt + 1;
      modelStep();
   endtask

   // Monitor: grants every cycle, done against the scoreboard head, held values otherwise
   initial begin
      job_t e;
      int   inG;
      forever begin
         @(posedge clk);
         edgeCnt++;
         #1;
         inG = (edgeCnt >= gStart && edgeCnt <= gEnd) ? 1 : 0;
         checkOutput("gnt0", int'(gnt0), (inG == 1 && gOwner == 0) ? 1 : 0);
         checkOutput("gnt1", int'(gnt1), (inG == 1 && gOwner == 1) ? 1 : 0);
         checkOutput("busy", int'(busy), inG);
         if (sb.size() > 0 && sb[0].edgeNo < edgeCnt) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_missing: got no done, expected done at edge %0d", sb[0].edgeNo);
            void'(sb.pop_front());
         end
         if (done) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL spurious_done: got done=1, expected 0 (edge %0d)", edgeCnt);
            end else begin
               e = sb.pop_front();
               checkOutput("done_edge", edgeCnt, e.edgeNo);
               checkOutput("result", int'(result), e.res);
               checkOutput("ovf", int'(ovf), e.ovf);
               checkOutput("done_id", int'(done_id), e.id);
               heldRes = e.res;
               heldOvf = e.ovf;
               heldId = e.id;
            end
         end else begin
            checkOutput("held_result", int'(result), heldRes);
            checkOutput("held_ovf", int'(ovf), heldOvf);
            checkOutput("held_done_id", int'(done_id), heldId);
         end
      end
   end

   initial begin
      logic         r0;
      logic         r1;
      logic [W-1:0] a;
      logic [W-1:0] b;
      modelReset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      freeEdge = edgeCnt + 1;
      modelStep();

      $display("[TB] single job n0=5");
      applyStimulus(1'b1, 1'b0, 11'd5, 11'd0);
      idle(10);

      $display("[TB] overflow job n1=150");
      applyStimulus(1'b0, 1'b1, 11'd0, 11'd150);
      idle(160);

      $display("[TB] tie and rotation n0=3 n1=4");
      for (int t = 0; t < 19; t++) applyStimulus(1'b1, 1'b1, 11'd3, 11'd4);
      idle(10);

      $display("[TB] zero bound and bound change mid-job");
      applyStimulus(1'b1, 1'b0, 11'd0, 11'd0);
      idle(5);
      applyStimulus(1'b1, 1'b0, 11'd4, 11'd0);
      for (int t = 0; t < 10; t++) applyStimulus(1'b0, 1'b0, 11'd9, 11'd0);

      $display("[TB] reset during a running job");
      applyStimulus(1'b1, 1'b0, 11'd20, 11'd0);
      idle(5);
      pulseReset(1'b1, 1'b1, 11'd3, 11'd4);
      for (int t = 0; t < 8; t++) applyStimulus(1'b1, 1'b1, 11'd3, 11'd4);
      idle(10);

      $display("[TB] randomized traffic");
      for (int t = 0; t < 2500; t++) begin
         r0 = ($urandom_range(0, 2) != 0);
         r1 = ($urandom_range(0, 2) != 0);
         a = ($urandom_range(0, 19) == 0) ? W'($urandom_range(100, 300)) : W'($urandom_range(0, 25));
         b = ($urandom_range(0, 19) == 0) ? W'($urandom_range(100, 300)) : W'($urandom_range(0, 25));
         applyStimulus(r0, r1, a, b);
      end
      idle(400);
      checkOutput("queue_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
